ara_req_broadcast: RTL and testbench

Broadcasts accelerator requests from the scalar core to all `NrClusters` Ara instances and joins their responses into one. Sits directly upstream of the cluster array, between the core's accelerator port and the per-cluster request/response ports. Each cluster may accept a request in a different cycle; the response is released only after every cluster has answered. The block bounds in-flight requests and flags any divergence between cluster responses.

---
 rtl/ara_req_broadcast.sv | 126 ++++++++++++
 tb/tb_ara_req_broadcast.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ara_req_broadcast.sv
// Broadcasts one core accelerator request to every Ara cluster and joins the per-cluster
// responses into a single upstream response, bounding in-flight requests and flagging divergence.
module ara_req_broadcast #(
   parameter int unsigned NrClusters     = 4,
   parameter int unsigned MaxOutstanding = 4,
   parameter type         req_t          = logic,
   parameter type         resp_t         = logic,
   localparam int unsigned ReqW          = $bits(req_t),
   localparam int unsigned RespW         = $bits(resp_t),
   localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                slv_req_valid_i,
   output logic                                slv_req_ready_o,
   input  logic [ReqW-1:0]                     slv_req_i,
   output logic [NrClusters-1:0]               mst_req_valid_o,
   input  logic [NrClusters-1:0]               mst_req_ready_i,
   output logic [ReqW-1:0]                     mst_req_o,
   input  logic [NrClusters-1:0]               mst_resp_valid_i,
   output logic [NrClusters-1:0]               mst_resp_ready_o,
   input  logic [NrClusters-1:0][RespW-1:0]    mst_resp_i,
   output logic                                slv_resp_valid_o,
   input  logic                                slv_resp_ready_i,
   output logic [RespW-1:0]                    slv_resp_o,
   output logic                                resp_mismatch_o,
   output logic [CntW-1:0]                     outstanding_o
);

   localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

   logic [ReqW-1:0]       req_q, req_d;
   logic [NrClusters-1:0] pend_q, pend_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  mismatch_q, mismatch_d;

   logic                  drain, req_hs, resp_hs;
   logic [NrClusters-1:0] held_vec;
   logic [NrClusters-1:0] diff_vec;
   logic [RespW-1:0]      rsp_vec [NrClusters];

   // The request register empties this cycle if every still-pending cluster is ready now.
   assign drain           = ((pend_q & ~mst_req_ready_i) == '0);
   assign slv_req_ready_o = drain && (cnt_q < MaxCnt);
   assign req_hs          = slv_req_valid_i && slv_req_ready_o;
   assign resp_hs         = slv_resp_valid_o && slv_resp_ready_i;

   assign mst_req_valid_o  = pend_q;
   assign mst_req_o        = req_q;
   assign mst_resp_ready_o = ~held_vec;
   assign slv_resp_valid_o = &held_vec;
   assign slv_resp_o       = rsp_vec[0];
   assign resp_mismatch_o  = mismatch_q;
   assign outstanding_o    = cnt_q;

   always_comb begin
      req_d  = req_q;
      pend_d = pend_q & ~mst_req_ready_i;
      if (req_hs) begin
         req_d  = slv_req_i;
         pend_d = '1;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (req_hs && !resp_hs) begin
         cnt_d = cnt_q + 1'b1;
      end else if (!req_hs && resp_hs && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   assign mismatch_d = mismatch_q | ((&held_vec) & (|diff_vec));

   for (genvar gi = 0; gi < NrClusters; gi++) begin : g_cluster
      logic             held_q, held_d;
      logic [RespW-1:0] rsp_q, rsp_d;

      // Upstream release clears the slot; ready stays low that cycle, so no capture can collide.
      always_comb begin
         held_d = held_q;
         rsp_d  = rsp_q;
         if (resp_hs) begin
            held_d = 1'b0;
         end else if (mst_resp_valid_i[gi] && !held_q) begin
            held_d = 1'b1;
            rsp_d  = mst_resp_i[gi];
         end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            held_q <= 1'b0;
            rsp_q  <= '0;
         end else begin
            held_q <= held_d;
            rsp_q  <= rsp_d;
         end
      end

      assign held_vec[gi] = held_q;
      assign rsp_vec[gi]  = rsp_q;

      if (gi == 0) begin : g_ref
         assign diff_vec[gi] = 1'b0;
      end else begin : g_cmp
         assign diff_vec[gi] = (rsp_q != rsp_vec[0]);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         req_q      <= '0;
         pend_q     <= '0;
         cnt_q      <= '0;
         mismatch_q <= 1'b0;
      end else begin
         req_q      <= req_d;
         pend_q     <= pend_d;
         cnt_q      <= cnt_d;
         mismatch_q <= mismatch_d;
      end
   end

endmodule

// File: tb/tb_ara_req_broadcast.sv
// Cycle-by-cycle vector bench for ara_req_broadcast (4 clusters, 2 outstanding, 8-bit payloads),
// followed by a hand-written asynchronous-reset sequence.
module tb_ara_req_broadcast;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic              slv_req_valid_i;
   logic              slv_req_ready_o;
   logic [7:0]        slv_req_i;
   logic [3:0]        mst_req_valid_o;
   logic [3:0]        mst_req_ready_i;
   logic [7:0]        mst_req_o;
   logic [3:0]        mst_resp_valid_i;
   logic [3:0]        mst_resp_ready_o;
   logic [3:0][7:0]   mst_resp_i;
   logic              slv_resp_valid_o;
   logic              slv_resp_ready_i;
   logic [7:0]        slv_resp_o;
   logic              resp_mismatch_o;
   logic [1:0]        outstanding_o;

   int checks = 0;
   int errors = 0;

   ara_req_broadcast #(
      .NrClusters    (4),
      .MaxOutstanding(2),
      .req_t         (logic [7:0]),
      .resp_t        (logic [7:0])
   ) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .slv_req_valid_i (slv_req_valid_i),
      .slv_req_ready_o (slv_req_ready_o),
      .slv_req_i       (slv_req_i),
      .mst_req_valid_o (mst_req_valid_o),
      .mst_req_ready_i (mst_req_ready_i),
      .mst_req_o       (mst_req_o),
      .mst_resp_valid_i(mst_resp_valid_i),
      .mst_resp_ready_o(mst_resp_ready_o),
      .mst_resp_i      (mst_resp_i),
      .slv_resp_valid_o(slv_resp_valid_o),
      .slv_resp_ready_i(slv_resp_ready_i),
      .slv_resp_o      (slv_resp_o),
      .resp_mismatch_o (resp_mismatch_o),
      .outstanding_o   (outstanding_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        rv;
      logic [7:0]  rd;
      logic [3:0]  mr;
      logic [3:0]  sv;
      logic [31:0] sd;
      logic        ur;
      logic        e_rr;
      logic [3:0]  e_mv;
      logic [7:0]  e_md;
      logic [3:0]  e_pr;
      logic        e_uv;
      logic [7:0]  e_ud;
      logic        e_mm;
      logic [1:0]  e_cnt;
   } vec_t;

   localparam int NV = 31;
   vec_t vecs [NV];

   task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (row %0d): got 0x%0h, expected 0x%0h", name, row, act, exp);
      end
   endtask

   task automatic drive_idle();
      slv_req_valid_i  = 1'b0;
      slv_req_i        = 8'h00;
      mst_req_ready_i  = 4'h0;
      mst_resp_valid_i = 4'h0;
      mst_resp_i       = '0;
      slv_resp_ready_i = 1'b0;
   endtask

   initial begin
      //           rv  rd     mr    sv    sd             ur  | rr  mv    md     pr    uv  ud     mm  cnt
      // single request, all ready; then staggered response join of 0x11
      vecs[0]  = '{1, 8'hA5, 4'hF, 4'h0, 32'h00000000, 0,    1, 4'h0, 8'h00, 4'hF, 0, 8'h00, 0, 2'd0};
      vecs[1]  = '{0, 8'h00, 4'hF, 4'h0, 32'h00000000, 0,    1, 4'hF, 8'hA5, 4'hF, 0, 8'h00, 0, 2'd1};
      vecs[2]  = '{0, 8'h00, 4'h0, 4'h1, 32'h00000011, 0,    1, 4'h0, 8'hA5, 4'hF, 0, 8'h00, 0, 2'd1};
      vecs[3]  = '{0, 8'h00, 4'h0, 4'h0, 32'h00000000, 0,    1, 4'h0, 8'hA5, 4'hE, 0, 8'h11, 0, 2'd1};
      vecs[4]  = '{0, 8'h00, 4'h0, 4'h0, 32'h00000000, 0,    1, 4'h0, 8'hA5, 4'hE, 0, 8'h11, 0, 2'd1};
      vecs[5]  = '{0, 8'h00, 4'h0, 4'h6, 32'h00111100, 0,    1, 4'h0, 8'hA5, 4'hE, 0, 8'h11, 0, 2'd1};
      vecs[6]  = '{0, 8'h00, 4'h0, 4'h0, 32'h00000000, 0,    1, 4'h0, 8'hA5, 4'h8, 0, 8'h11, 0, 2'd1};
      vecs[7]  = '{0, 8'h00, 4'h0, 4'h0, 32'h00000000, 0,    1, 4'h0, 8'hA5, 4'h8, 0, 8'h11, 0, 2'd1};
      vecs[8]  = '{0, 8'h00, 4'h0, 4'h8, 32'h11000000, 0,    1, 4'h0, 8'hA5, 4'h8, 0, 8'h11, 0, 2'd1};
      vecs[9]  = '{0, 8'h00, 4'h0, 4'h0, 32'h00000000, 0,    1, 4'h0, 8'hA5, 4'h0, 1, 8'h11, 0, 2'd1};
      vecs[10] = '{0, 8'h00, 4'h0, 4'h0, 32'h00000000, 1,    1, 4'h0, 8'hA5, 4'h0, 1, 8'h11, 0, 2'd1};
      vecs[11] = '{0, 8'h00, 4'h0, 4'h0, 32'h00000000, 0,    1, 4'h0, 8'hA5, 4'hF, 0, 8'h11, 0, 2'd0};
      // staggered acceptance 1,3,3,6, with a new request loaded in the draining cycle
      vecs[12] = '{1, 8'h5A, 4'h0, 4'h0, 32'h00000000, 0,    1, 4'h0, 8'hA5, 4'hF, 0, 8'h11, 0, 2'd0};
      vecs[13] = '{0, 8'h00, 4'h1, 4'h0, 32'h00000000, 0,    0, 4'hF, 8'h5A, 4'hF, 0, 8'h11, 0, 2'd1};
      vecs[14] = '{0, 8'h00, 4'h0, 4'h0, 32'h00000000, 0,    0, 4'hE, 8'h5A, 4'hF, 0, 8'h11, 0, 2'd1};
      vecs[15] = '{0, 8'h00, 4'h6, 4'h0, 32'h00000000, 0,    0, 4'hE, 8'h5A, 4'hF, 0, 8'h11, 0, 2'd1};
      vecs[16] = '{0, 8'h00, 4'h0, 4'h0, 32'h00000000, 0,    0, 4'h8, 8'h5A, 4'hF, 0, 8'h11, 0, 2'd1};
      vecs[17] = '{0, 8'h00, 4'h0, 4'h0, 32'h00000000, 0,    0, 4'h8, 8'h5A, 4'hF, 0, 8'h11, 0, 2'd1};
      vecs[18] = '{1, 8'hC3, 4'h8, 4'h0, 32'h00000000, 0,    1, 4'h8, 8'h5A, 4'hF, 0, 8'h11, 0, 2'd1};
      // counter full: third request stalls; divergent response from cluster 2
      vecs[19] = '{1, 8'h77, 4'hF, 4'h0, 32'h00000000, 0,    0, 4'hF, 8'hC3, 4'hF, 0, 8'h11, 0, 2'd2};
      vecs[20] = '{1, 8'h77, 4'hF, 4'hF, 32'h11121111, 0,    0, 4'h0, 8'hC3, 4'hF, 0, 8'h11, 0, 2'd2};
      vecs[21] = '{1, 8'h77, 4'hF, 4'h0, 32'h00000000, 1,    0, 4'h0, 8'hC3, 4'h0, 1, 8'h11, 0, 2'd2};
      vecs[22] = '{1, 8'h77, 4'hF, 4'h0, 32'h00000000, 0,    1, 4'h0, 8'hC3, 4'hF, 0, 8'h11, 1, 2'd1};
      vecs[23] = '{0, 8'h00, 4'hF, 4'hF, 32'h22222222, 0,    0, 4'hF, 8'h77, 4'hF, 0, 8'h11, 1, 2'd2};
      vecs[24] = '{1, 8'h99, 4'hF, 4'h0, 32'h00000000, 1,    0, 4'h0, 8'h77, 4'h0, 1, 8'h22, 1, 2'd2};
      vecs[25] = '{1, 8'h99, 4'hF, 4'hF, 32'h33333333, 0,    1, 4'h0, 8'h77, 4'hF, 0, 8'h22, 1, 2'd1};
      vecs[26] = '{0, 8'h00, 4'hF, 4'h0, 32'h00000000, 1,    0, 4'hF, 8'h99, 4'h0, 1, 8'h33, 1, 2'd2};
      vecs[27] = '{0, 8'h00, 4'hF, 4'hF, 32'h44444444, 0,    1, 4'h0, 8'h99, 4'hF, 0, 8'h33, 1, 2'd1};
      // simultaneous request and response handshake keeps the count
      vecs[28] = '{1, 8'hAB, 4'h0, 4'h0, 32'h00000000, 1,    1, 4'h0, 8'h99, 4'h0, 1, 8'h44, 1, 2'd1};
      vecs[29] = '{0, 8'h00, 4'h0, 4'h0, 32'h00000000, 0,    0, 4'hF, 8'hAB, 4'hF, 0, 8'h44, 1, 2'd1};
      // leave pend=0110, held=0011 for the reset sequence
      vecs[30] = '{0, 8'h00, 4'h9, 4'h3, 32'h00005555, 0,    0, 4'hF, 8'hAB, 4'hF, 0, 8'h44, 1, 2'd1};

      drive_idle();
      rst_ni = 1'b0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;

      for (int i = 0; i < NV; i++) begin
         @(posedge clk_i);
         #1;
         slv_req_valid_i  = vecs[i].rv;
         slv_req_i        = vecs[i].rd;
         mst_req_ready_i  = vecs[i].mr;
         mst_resp_valid_i = vecs[i].sv;
         mst_resp_i       = vecs[i].sd;
         slv_resp_ready_i = vecs[i].ur;
         @(negedge clk_i);
         chk("slv_req_ready",  i, 32'(slv_req_ready_o),  32'(vecs[i].e_rr));
         chk("mst_req_valid",  i, 32'(mst_req_valid_o),  32'(vecs[i].e_mv));
         chk("mst_req",        i, 32'(mst_req_o),        32'(vecs[i].e_md));
         chk("mst_resp_ready", i, 32'(mst_resp_ready_o), 32'(vecs[i].e_pr));
         chk("slv_resp_valid", i, 32'(slv_resp_valid_o), 32'(vecs[i].e_uv));
         chk("slv_resp",       i, 32'(slv_resp_o),       32'(vecs[i].e_ud));
         chk("resp_mismatch",  i, 32'(resp_mismatch_o),  32'(vecs[i].e_mm));
         chk("outstanding",    i, 32'(outstanding_o),    32'(vecs[i].e_cnt));
         $display("row %0d: req_rdy=%b mst_vld=%b mst_req=%h rsp_rdy=%b rsp_vld=%b rsp=%h mm=%b cnt=%0d",
                  i, slv_req_ready_o, mst_req_valid_o, mst_req_o, mst_resp_ready_o,
                  slv_resp_valid_o, slv_resp_o, resp_mismatch_o, outstanding_o);
      end

      // Asynchronous reset in the middle of a cycle with partial state
      @(posedge clk_i);
      #1;
      drive_idle();
      chk("pre_rst_mst_req_valid",  100, 32'(mst_req_valid_o),  32'h6);
      chk("pre_rst_mst_resp_ready", 100, 32'(mst_resp_ready_o), 32'hC);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("rst_slv_req_ready",  101, 32'(slv_req_ready_o),  32'h1);
      chk("rst_mst_req_valid",  101, 32'(mst_req_valid_o),  32'h0);
      chk("rst_mst_req",        101, 32'(mst_req_o),        32'h0);
      chk("rst_mst_resp_ready", 101, 32'(mst_resp_ready_o), 32'hF);
      chk("rst_slv_resp_valid", 101, 32'(slv_resp_valid_o), 32'h0);
      chk("rst_slv_resp",       101, 32'(slv_resp_o),       32'h0);
      chk("rst_resp_mismatch",  101, 32'(resp_mismatch_o),  32'h0);
      chk("rst_outstanding",    101, 32'(outstanding_o),    32'h0);
      $display("reset: mst_vld=%b rsp_rdy=%b mm=%b cnt=%0d",
               mst_req_valid_o, mst_resp_ready_o, resp_mismatch_o, outstanding_o);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // New request after reset broadcasts normally
      @(posedge clk_i);
      #1;
      slv_req_valid_i = 1'b1;
      slv_req_i       = 8'h3C;
      mst_req_ready_i = 4'hF;
      #1;
      chk("post_rst_slv_req_ready", 102, 32'(slv_req_ready_o), 32'h1);
      @(posedge clk_i);
      #1;
      slv_req_valid_i = 1'b0;
      chk("post_rst_mst_req_valid", 103, 32'(mst_req_valid_o), 32'hF);
      chk("post_rst_mst_req",       103, 32'(mst_req_o),       32'h3C);
      chk("post_rst_outstanding",   103, 32'(outstanding_o),   32'h1);
      $display("post-reset: mst_vld=%b mst_req=%h cnt=%0d", mst_req_valid_o, mst_req_o, outstanding_o);
      @(posedge clk_i);
      #1;
      chk("post_rst_drained", 104, 32'(mst_req_valid_o), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
